// File: rtl/alu_pkg.sv
// Shared ALU op codes, opcode constants and branch conditions
// for the ALU issue/resolve controller.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SUBU = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_AND  = 4'b1001,
    ALU_SLT  = 4'b1010,
    ALU_SRA  = 4'b1100
  } alu_op_e;

  // Branch decision taken from zero/neg flags after a SUB/SUBU
  typedef enum logic [1:0] {
    BR_Z,
    BR_NZ,
    BR_N,
    BR_NN
  } br_cond_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between the issuing stage
// and the ALU issue controller.
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            illegal;

  modport master (
    output in_valid, opcode, funct3, funct7_5,
    output rs1_val, rs2_val, imm, out_ready,
    input  in_ready, out_valid, result,
    input  branch_taken, illegal
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7_5,
    input  rs1_val, rs2_val, imm, out_ready,
    output in_ready, out_valid, result,
    output branch_taken, illegal
  );

endinterface

// File: rtl/alu_op_decode.sv
// Maps opcode/funct3/funct7[5] to the ALU op, operand select,
// branch condition and an illegal-encoding flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    alu_op,
  output logic       use_imm,
  output logic       is_branch,
  output br_cond_e   br_cond,
  output logic       illegal
);

  alu_op_e base_op;

  always_comb begin
    unique case (funct3)
      3'b000: base_op = ALU_ADD;
      3'b001: base_op = ALU_SLL;
      3'b010: base_op = ALU_SLT;
      3'b011: base_op = ALU_SLTU;
      3'b100: base_op = ALU_XOR;
      3'b101: base_op = ALU_SRL;
      3'b110: base_op = ALU_OR;
      3'b111: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    alu_op    = base_op;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    br_cond   = BR_Z;
    illegal   = 1'b0;
    unique case (1'b1)
      opcode == OP_R: begin
        if (funct7_5) begin
          unique case (funct3)
            3'b000:  alu_op  = ALU_SUB;
            3'b101:  alu_op  = ALU_SRA;
            default: illegal = 1'b1;
          endcase
        end
      end
      opcode == OP_I: begin
        use_imm = 1'b1;
        // funct7[5] is part of the immediate except on shifts
        if (funct3 == 3'b001)
          illegal = funct7_5;
        if (funct3 == 3'b101 && funct7_5)
          alu_op = ALU_SRA;
      end
      opcode == OP_BR: begin
        is_branch = 1'b1;
        unique case (funct3)
          3'b000: begin
            alu_op  = ALU_SUB;
            br_cond = BR_Z;
          end
          3'b001: begin
            alu_op  = ALU_SUB;
            br_cond = BR_NZ;
          end
          3'b100: begin
            alu_op  = ALU_SUB;
            br_cond = BR_N;
          end
          3'b101: begin
            alu_op  = ALU_SUB;
            br_cond = BR_NN;
          end
          3'b110: begin
            alu_op  = ALU_SUBU;
            br_cond = BR_N;
          end
          3'b111: begin
            alu_op  = ALU_SUBU;
            br_cond = BR_NN;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/resolve controller: registers ALU operands for one EXEC
// cycle, then returns the result or branch decision.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave bus,
  output logic [XLEN-1:0] alu_in_1,
  output logic [XLEN-1:0] alu_in_2,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic            alu_pos
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] result_q;
  logic            taken_q;
  logic            illegal_q;
  logic            branch_q;
  br_cond_e        br_q;

  alu_op_e  dec_op;
  logic     dec_imm;
  logic     dec_branch;
  br_cond_e dec_cond;
  logic     dec_illegal;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] op_b_fin;
  logic            is_shift;
  logic            taken;
  logic            flags_unused;

  alu_op_decode u_dec (
    .opcode    (bus.opcode),
    .funct3    (bus.funct3),
    .funct7_5  (bus.funct7_5),
    .alu_op    (dec_op),
    .use_imm   (dec_imm),
    .is_branch (dec_branch),
    .br_cond   (dec_cond),
    .illegal   (dec_illegal)
  );

  assign flags_unused = alu_pos;

  assign op_b     = dec_imm ? bus.imm : bus.rs2_val;
  assign is_shift = dec_op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  // Shift amount is masked so the ALU never sees more than 31
  assign op_b_fin = is_shift ?
                    {{(XLEN-5){1'b0}}, op_b[4:0]} : op_b;

  always_comb begin
    unique case (br_q)
      BR_Z:  taken = alu_zero;
      BR_NZ: taken = ~alu_zero;
      BR_N:  taken = alu_neg;
      BR_NN: taken = ~alu_neg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      alu_in_1    <= '0;
      alu_in_2    <= '0;
      alu_control <= '0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      branch_q    <= 1'b0;
      br_q        <= BR_Z;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            illegal_q <= dec_illegal;
            result_q  <= '0;
            taken_q   <= 1'b0;
            if (dec_illegal) begin
              state <= S_RESP;
            end else begin
              alu_in_1    <= bus.rs1_val;
              alu_in_2    <= op_b_fin;
              alu_control <= dec_op;
              branch_q    <= dec_branch;
              br_q        <= dec_cond;
              state       <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          result_q <= branch_q ? '0 : alu_out;
          taken_q  <= branch_q & taken;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == S_IDLE);
  assign bus.out_valid    = (state == S_RESP);
  assign bus.result       = result_q;
  assign bus.branch_taken = taken_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/resolve controller on the driving side of the ALU in the RV32I core. It accepts one decoded instruction per handshake, classifies it from opcode/funct3/funct7[5], registers the ALU operands and `alu_control` code, then samples the ALU result and flags. It returns either a write-back value or a branch-taken decision on a valid/ready response channel, and reports illegal encodings.

## Interface
- `XLEN`, 32, datapath width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when high with `in_valid`.
- `opcode`  in  7  instruction[6:0].
- `funct3`  in  3  instruction[14:12].
- `funct7_5`  in  1  instruction[30].
- `rs1_val`, `rs2_val`, `imm`  in  XLEN  operand values; `imm` is already sign-extended.
- `alu_in_1`, `alu_in_2`  out  XLEN  registered ALU operands.
- `alu_control`  out  4  registered ALU op code.
- `alu_out`  in  XLEN  ALU result.
- `alu_zero`, `alu_neg`, `alu_pos`  in  1  ALU flags.
- `out_valid`  out  1  response valid.
- `out_ready`  in  1  response consumed.
- `result`  out  XLEN  ALU result for R/I ops; 0 for branches and illegal encodings.
- `branch_taken`  out  1  branch decision; 0 for non-branches.
- `illegal`  out  1  unsupported encoding.

## Operation
- FSM has three states: IDLE, EXEC, RESP. `in_ready` = (state == IDLE).
- **IDLE**, handshake:
  - Legal encoding: register operands and code, go to EXEC.
  - Illegal encoding: set `illegal` = 1, `result` = 0, `branch_taken` = 0, go to RESP directly.
- **EXEC**: lasts one cycle. `alu_control` and operands are stable throughout. At the end of the cycle, capture `alu_out` into `result` (or compute `branch_taken` from the flags), then go to RESP.
- **RESP**: `out_valid` = 1. Response fields hold until `out_ready`. On handshake, go to IDLE.
- Opcode `0110011` (R-type), funct3 -> op:
  - 000 -> ADD, or SUB if `funct7_5`
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101 -> SRL, or SRA if `funct7_5`
  - 110 OR, 111 AND
  - `funct7_5` = 1 with any other funct3 is illegal.
- Opcode `0010011` (I-type): same mapping with `alu_in_2` = `imm`, with two differences:
  - funct3 000 is always ADD.
  - `funct7_5` is checked only for funct3 001 (must be 0) and 101.
- Opcode `1100011` (branch), with `alu_in_2` = `rs2_val`:
  - 000 BEQ: SUB, taken = zero.
  - 001 BNE: SUB, taken = !zero.
  - 100 BLT: SUB, taken = neg.
  - 101 BGE: SUB, taken = !neg.
  - 110 BLTU: SUBU, taken = neg.
  - 111 BGEU: SUBU, taken = !neg.
  - 010 and 011 are illegal.
- Any other opcode is illegal.
- Shifts: `alu_in_2` = {27'b0, operand[4:0]}. The upper bits are masked here, so the ALU shift amount never exceeds 31.
- `alu_control` encodings: ADD 0010, SUB 0110, SLL 0100, SLT 1010, SLTU 0101, XOR 0011, SRL 1000, SRA 1100, OR 0001, AND 1001, SUBU 0111. These codes are normative. The ALU decodes OR as 0001 and XOR as 0011.

## Timing
- Reset values: state IDLE; all outputs 0, except `in_ready` = 1.
- Legal request accepted at edge k: EXEC during cycle k+1, `out_valid` from edge k+2.
- Illegal request accepted at edge k: `out_valid` from edge k+1.
- Throughput: at most one request per 3 cycles, with `out_ready` tied high.
- `out_valid` must not drop, and response fields must not change, until the handshake completes.
- No request is accepted in the same cycle as a response handshake.
- `alu_in_*` and `alu_control` hold their last values outside EXEC; they are don't-care there.
- `rst_n` low in any state: immediate return to IDLE with reset output values. No response is produced for the in-flight request.

## Structure
- Shared package `alu_pkg` holds:
  - the `alu_op_e` enum with the 4-bit codes above;
  - opcode constants `OP_R`, `OP_I`, `OP_BR`;
  - the `br_cond_e` enum.
- One combinational sub-module, `alu_op_decode`, maps (opcode, funct3, funct7_5) -> (alu_op, use_imm, is_branch, br_cond, illegal).
- The FSM and registers live in the top module.

## Test plan
- R-type ADD, `rs1` = 5, `rs2` = 7, `out_ready` = 1 -> `alu_control` = 0010 in EXEC; `result` = 12, `out_valid` at k+2.
- SRAI, `funct7_5` = 1, `rs1` = 0x80000000, `imm` = 0x404 -> `alu_in_2` = 4, `alu_control` = 1100.
- BLTU with `rs1` = 1, `rs2` = 0xFFFFFFFF (ALU neg = 1) -> `branch_taken` = 1, `result` = 0. BGE with `rs1` = -1, `rs2` = 0 -> `branch_taken` = 0.
- Opcode `0110011`, funct3 001, `funct7_5` = 1 -> `illegal` = 1, `out_valid` at k+1, `alu_control` unchanged.
- Hold `out_ready` = 0 for 5 cycles in RESP -> `out_valid` and `result` stable; `in_ready` = 0 until the handshake.
- Assert `rst_n` low during EXEC -> `out_valid` = 0 and `in_ready` = 1 immediately; the next request completes normally.
